// File: rtl/bsr_mem_arb.sv
`default_nettype none
// ==========================================================================
// bsr_mem_arb : registered I/D arbiter for the shared memory tile port
// Rev 1.0 - initial release
// ==========================================================================
module bsr_mem_arb #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [4:0]   icOpm,
   input  logic [19:0]  icAddr,
   output logic [127:0] icData,
   output logic [1:0]   icOK,
   input  logic [4:0]   dcOpm,
   input  logic [19:0]  dcAddr,
   input  logic [127:0] dcDataO,
   output logic [127:0] dcDataI,
   output logic [1:0]   dcOK,
   output logic [4:0]   memOpm,
   output logic [19:0]  memAddr,
   output logic [127:0] memDataO,
   input  logic [127:0] memDataI,
   input  logic [1:0]   memOK,
   output logic [1:0]   arbGrant,
   output logic         arbFault
);

   localparam logic [1:0] c_READY = 2'd0;
   localparam logic [1:0] c_OK    = 2'd1;
   localparam logic [1:0] c_HOLD  = 2'd2;
   localparam logic [1:0] c_FAULT = 2'd3;

   localparam logic [2:0] c_STARVE   = 3'(STARVE_MAX);
   localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GNT_I   = 2'd1,
      S_GNT_D   = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_grant, w_grant_nxt;
   logic        r_owner_d, w_owner_d_nxt;
   logic [2:0]  r_starve, w_starve_nxt;
   logic [7:0]  r_tmo, w_tmo_nxt;
   logic        r_faulted, w_faulted_nxt;

   logic        w_ireq, w_dreq;
   logic [4:0]  w_own_opm;
   logic [1:0]  w_own_ok;

   assign w_ireq    = (icOpm != 5'd0);
   assign w_dreq    = (dcOpm != 5'd0);
   assign w_own_opm = r_owner_d ? dcOpm : icOpm;
   assign arbGrant  = r_grant;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_grant   <= 2'b00;
         r_owner_d <= 1'b0;
         r_starve  <= 3'd0;
         r_tmo     <= 8'd0;
         r_faulted <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_owner_d <= w_owner_d_nxt;
         r_starve  <= w_starve_nxt;
         r_tmo     <= w_tmo_nxt;
         r_faulted <= w_faulted_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_owner_d_nxt = r_owner_d;
      w_starve_nxt  = r_starve;
      w_tmo_nxt     = r_tmo;
      w_faulted_nxt = r_faulted;
      w_own_ok      = c_READY;
      memOpm        = 5'd0;
      memAddr       = 20'd0;
      memDataO      = 128'd0;
      icOK          = c_READY;
      dcOK          = c_READY;
      icData        = 128'd0;
      dcDataI       = 128'd0;
      arbFault      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tmo_nxt     = 8'd0;
            w_faulted_nxt = 1'b0;
            if (!w_dreq)
               w_starve_nxt = 3'd0;
            if (w_ireq && w_dreq && (r_starve >= c_STARVE)) begin
               w_state_nxt   = S_GNT_D;
               w_grant_nxt   = 2'b10;
               w_owner_d_nxt = 1'b1;
               w_starve_nxt  = 3'd0;
            end else if (w_ireq) begin
               w_state_nxt   = S_GNT_I;
               w_grant_nxt   = 2'b01;
               w_owner_d_nxt = 1'b0;
               if (w_dreq && (r_starve != 3'd7))
                  w_starve_nxt = r_starve + 3'd1;
            end else if (w_dreq) begin
               w_state_nxt   = S_GNT_D;
               w_grant_nxt   = 2'b10;
               w_owner_d_nxt = 1'b1;
               w_starve_nxt  = 3'd0;
            end
         end

         S_GNT_I, S_GNT_D: begin
            memOpm  = w_own_opm;
            memAddr = r_owner_d ? dcAddr : icAddr;
            if (r_owner_d)
               memDataO = dcDataO;
            w_own_ok = memOK;
            if (memOK != c_OK)
               w_tmo_nxt = r_tmo + 8'd1;
            // Memory completion/fault outranks the timeout on the same cycle.
            if ((memOK == c_OK) || (memOK == c_FAULT)) begin
               w_state_nxt   = S_RELEASE;
               w_faulted_nxt = (memOK == c_FAULT);
               w_tmo_nxt     = 8'd0;
            end else if (r_tmo == c_TMO_LAST) begin
               // r_tmo counts previous stalled cycles, so this is stall TIMEOUT.
               w_own_ok      = c_FAULT;
               arbFault      = 1'b1;
               w_state_nxt   = S_RELEASE;
               w_faulted_nxt = 1'b1;
               w_tmo_nxt     = 8'd0;
            end
         end

         S_RELEASE: begin
            if (w_own_opm != 5'd0)
               w_own_ok = r_faulted ? c_FAULT : c_OK;
            if ((w_own_opm == 5'd0) && (memOK == c_READY)) begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = 2'b00;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 2'b00;
         end
      endcase

      if (r_state != S_IDLE) begin
         if (r_owner_d) begin
            dcOK    = w_own_ok;
            dcDataI = memDataI;
            icOK    = w_ireq ? c_HOLD : c_READY;
         end else begin
            icOK    = w_own_ok;
            icData  = memDataI;
            dcOK    = w_dreq ? c_HOLD : c_READY;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bsr_mem_arb.sv
`default_nettype none
// Directed self-checking bench for bsr_mem_arb.
module tb_bsr_mem_arb;

   localparam logic [1:0] READY = 2'd0;
   localparam logic [1:0] OK    = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] FLT   = 2'd3;

   logic         clock = 1'b0;
   logic         reset;
   logic [4:0]   icOpm;
   logic [19:0]  icAddr;
   logic [127:0] icData;
   logic [1:0]   icOK;
   logic [4:0]   dcOpm;
   logic [19:0]  dcAddr;
   logic [127:0] dcDataO;
   logic [127:0] dcDataI;
   logic [1:0]   dcOK;
   logic [4:0]   memOpm;
   logic [19:0]  memAddr;
   logic [127:0] memDataO;
   logic [127:0] memDataI;
   logic [1:0]   memOK;
   logic [1:0]   arbGrant;
   logic         arbFault;

   int n_cmp = 0;
   int n_err = 0;

   bsr_mem_arb #(.STARVE_MAX(4), .TIMEOUT(255)) dut (
      .clock(clock), .reset(reset),
      .icOpm(icOpm), .icAddr(icAddr), .icData(icData), .icOK(icOK),
      .dcOpm(dcOpm), .dcAddr(dcAddr), .dcDataO(dcDataO), .dcDataI(dcDataI), .dcOK(dcOK),
      .memOpm(memOpm), .memAddr(memAddr), .memDataO(memDataO), .memDataI(memDataI),
      .memOK(memOK), .arbGrant(arbGrant), .arbFault(arbFault)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] a5;
      int early;
      a5 = {16{8'hA5}};
      reset = 1'b0; icOpm = '0; icAddr = '0; dcOpm = '0; dcAddr = '0;
      dcDataO = a5; memDataI = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; memOK = READY;

      // Reset state
      #2;
      chk("rst_memOpm", 128'(memOpm), 128'd0);
      chk("rst_grant", 128'(arbGrant), 128'd0);
      chk("rst_icOK", 128'(icOK), 128'(READY));
      chk("rst_dcOK", 128'(dcOK), 128'(READY));
      chk("rst_fault", 128'(arbFault), 128'd0);
      chk("rst_icData", icData, 128'd0);
      @(negedge clock);
      reset = 1'b1;

      // Lone I request
      tick(); icOpm = 5'h0F; icAddr = 20'h00100; settle();
      chk("t1_c0_grant", 128'(arbGrant), 128'd0);
      tick(); memOK = HOLD; settle();
      chk("t1_c1_grant", 128'(arbGrant), 128'b01);
      chk("t1_c1_addr", 128'(memAddr), 128'h00100);
      chk("t1_c1_opm", 128'(memOpm), 128'h0F);
      chk("t1_c1_icOK", 128'(icOK), 128'(HOLD));
      tick(); settle();
      tick(); memOK = OK; settle();
      chk("t1_c3_icOK", 128'(icOK), 128'(OK));
      chk("t1_c3_icData", icData, memDataI);
      tick(); icOpm = 5'h00; memOK = READY; settle();
      chk("t1_c4_opm", 128'(memOpm), 128'd0);
      chk("t1_c4_icOK", 128'(icOK), 128'(READY));
      tick(); settle();
      chk("t1_c5_grant", 128'(arbGrant), 128'd0);
      chk("t1_c5_addr", 128'(memAddr), 128'd0);

      // Simultaneous I and D, I wins with starve=0
      tick(); icOpm = 5'h0F; icAddr = 20'h00200; dcOpm = 5'h03; dcAddr = 20'h00300; settle();
      chk("t2_c0_grant", 128'(arbGrant), 128'd0);
      tick(); memOK = OK; settle();
      chk("t2_c1_grant", 128'(arbGrant), 128'b01);
      chk("t2_c1_addr", 128'(memAddr), 128'h00200);
      chk("t2_c1_dataO", memDataO, 128'd0);
      chk("t2_c1_dcOK", 128'(dcOK), 128'(HOLD));
      chk("t2_c1_icOK", 128'(icOK), 128'(OK));
      tick(); icOpm = 5'h00; memOK = READY; settle();
      chk("t2_c2_dcOK", 128'(dcOK), 128'(HOLD));
      chk("t2_c2_opm", 128'(memOpm), 128'd0);
      tick(); settle();
      chk("t2_c3_grant", 128'(arbGrant), 128'd0);
      tick(); memOK = OK; settle();
      chk("t2_c4_grant", 128'(arbGrant), 128'b10);
      chk("t2_c4_dataO", memDataO, a5);
      chk("t2_c4_addr", 128'(memAddr), 128'h00300);
      chk("t2_c4_opm", 128'(memOpm), 128'h03);
      chk("t2_c4_dcOK", 128'(dcOK), 128'(OK));
      chk("t2_c4_dcData", dcDataI, memDataI);
      tick(); dcOpm = 5'h00; memOK = READY; settle();
      chk("t2_c5_dcOK", 128'(dcOK), 128'(READY));
      tick(); settle();
      chk("t2_c6_grant", 128'(arbGrant), 128'd0);
      chk("t2_c6_starve", 128'(dut.r_starve), 128'd0);

      // Anti-starvation: four I transactions, then D is forced
      tick(); icOpm = 5'h0F; icAddr = 20'h00700; dcOpm = 5'h03; dcAddr = 20'h00300; settle();
      for (int k = 1; k <= 4; k++) begin
         tick(); memOK = OK; settle();
         chk($sformatf("t3_i%0d_grant", k), 128'(arbGrant), 128'b01);
         chk($sformatf("t3_i%0d_starve", k), 128'(dut.r_starve), 128'(k));
         tick(); icOpm = 5'h00; memOK = READY; settle();
         tick(); icOpm = 5'h0F; settle();
         chk($sformatf("t3_i%0d_idle", k), 128'(arbGrant), 128'd0);
      end
      tick(); memOK = OK; settle();
      chk("t3_d_grant", 128'(arbGrant), 128'b10);
      chk("t3_d_starve", 128'(dut.r_starve), 128'd0);
      chk("t3_d_icOK", 128'(icOK), 128'(HOLD));
      chk("t3_d_addr", 128'(memAddr), 128'h00300);
      tick(); icOpm = 5'h00; dcOpm = 5'h00; memOK = READY; settle();
      tick(); settle();
      chk("t3_end_grant", 128'(arbGrant), 128'd0);

      // Timeout on a D grant
      tick(); dcOpm = 5'h03; dcAddr = 20'h00400; memOK = HOLD; settle();
      early = 0;
      for (int k = 1; k <= 254; k++) begin
         tick(); settle();
         if (arbFault !== 1'b0 || dcOK !== HOLD || arbGrant !== 2'b10) early++;
      end
      chk("t4_early_cycles", 128'(early), 128'd0);
      tick(); settle();
      chk("t4_c255_dcOK", 128'(dcOK), 128'(FLT));
      chk("t4_c255_fault", 128'(arbFault), 128'd1);
      tick(); memOK = READY; settle();
      chk("t4_rel_fault", 128'(arbFault), 128'd0);
      chk("t4_rel_opm", 128'(memOpm), 128'd0);
      chk("t4_rel_dcOK", 128'(dcOK), 128'(FLT));
      tick(); dcOpm = 5'h00; settle();
      chk("t4_rel_ready", 128'(dcOK), 128'(READY));
      tick(); settle();
      chk("t4_idle_grant", 128'(arbGrant), 128'd0);

      // Asynchronous reset mid GNT_I
      tick(); icOpm = 5'h0F; icAddr = 20'h00500; memOK = HOLD; settle();
      tick(); settle();
      chk("t5_pre_opm", 128'(memOpm), 128'h0F);
      #2 reset = 1'b0;
      #1;
      chk("t5_rst_opm", 128'(memOpm), 128'd0);
      chk("t5_rst_grant", 128'(arbGrant), 128'd0);
      chk("t5_rst_icOK", 128'(icOK), 128'(READY));
      icOpm = 5'h00; dcOpm = 5'h07; dcAddr = 20'h00600;
      @(posedge clock);
      #1 reset = 1'b1;
      settle();
      chk("t5_rel_grant", 128'(arbGrant), 128'd0);

      // memOK FAULT during the D grant
      tick(); memOK = FLT; settle();
      chk("t6_grant", 128'(arbGrant), 128'b10);
      chk("t6_addr", 128'(memAddr), 128'h00600);
      chk("t6_dcOK", 128'(dcOK), 128'(FLT));
      chk("t6_fault", 128'(arbFault), 128'd0);
      tick(); memOK = READY; settle();
      chk("t6_rel_dcOK", 128'(dcOK), 128'(FLT));
      chk("t6_rel_fault", 128'(arbFault), 128'd0);
      chk("t6_rel_opm", 128'(memOpm), 128'd0);
      tick(); settle();
      chk("t6_rel2_dcOK", 128'(dcOK), 128'(FLT));
      tick(); dcOpm = 5'h00; settle();
      chk("t6_rel_ready", 128'(dcOK), 128'(READY));
      chk("t6_rel3_fault", 128'(arbFault), 128'd0);
      tick(); settle();
      chk("t6_idle_grant", 128'(arbGrant), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
